// File: rtl/sd2_adder_sched.sv
// sd2_adder_sched: second-order sigma-delta controller sharing one registered 16-bit adder.
// Revision 1.0
`default_nettype none
`timescale 1ns/1ps

module sd2_adder_sched #(
  parameter logic [15:0] FB_MAG = 16'h4000,
  parameter bit          SAT    = 1'b0
) (
  input  logic        clck,
  input  logic        rst_n,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] add_a,
  output logic [15:0] add_b,
  output logic        add_cin,
  input  logic [15:0] add_sum,
  input  logic        add_cout,
  output logic        dac_bit,
  output logic        dout_valid,
  output logic        ovf_flag,
  input  logic        ovf_clr
);

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_I1X  = 4'd1;
  localparam logic [3:0] S_W1X  = 4'd2;
  localparam logic [3:0] S_I1F  = 4'd3;
  localparam logic [3:0] S_W1F  = 4'd4;
  localparam logic [3:0] S_I2X  = 4'd5;
  localparam logic [3:0] S_W2X  = 4'd6;
  localparam logic [3:0] S_I2F  = 4'd7;
  localparam logic [3:0] S_W2F  = 4'd8;
  localparam logic [3:0] S_OUT  = 4'd9;

  logic [3:0]  state;
  logic [3:0]  state_nxt;
  logic [15:0] x_lat;
  logic [15:0] int1;
  logic [15:0] int2;
  logic        fb_sub;
  logic [15:0] fb_op;
  logic        fb_cin;
  logic        is_wait;
  logic        op_ovf;
  logic [15:0] cap_val;
  logic        unused_cout;

  assign unused_cout = add_cout;

  always_ff @(posedge clck) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (in_valid) state_nxt = S_I1X;
      S_I1X:   state_nxt = S_W1X;
      S_W1X:   state_nxt = S_I1F;
      S_I1F:   state_nxt = S_W1F;
      S_W1F:   state_nxt = S_I2X;
      S_I2X:   state_nxt = S_W2X;
      S_W2X:   state_nxt = S_I2F;
      S_I2F:   state_nxt = S_W2F;
      S_W2F:   state_nxt = S_OUT;
      S_OUT:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Feedback is subtracted: a - FB_MAG is issued as a + ~FB_MAG + 1.
  assign fb_op  = fb_sub ? ~FB_MAG : FB_MAG;
  assign fb_cin = fb_sub;

  always_comb begin
    in_ready   = 1'b0;
    dout_valid = 1'b0;
    add_a      = 16'h0000;
    add_b      = 16'h0000;
    add_cin    = 1'b0;
    case (state)
      S_IDLE: in_ready = 1'b1;
      S_I1X, S_W1X: begin
        add_a = int1;
        add_b = x_lat;
      end
      S_I1F, S_W1F: begin
        add_a   = int1;
        add_b   = fb_op;
        add_cin = fb_cin;
      end
      S_I2X, S_W2X: begin
        add_a = int2;
        add_b = int1;
      end
      S_I2F, S_W2F: begin
        add_a   = int2;
        add_b   = fb_op;
        add_cin = fb_cin;
      end
      S_OUT: dout_valid = 1'b1;
      default: ;
    endcase
  end

  // The adder result is only trusted in wait states, where the operands equal the issue cycle's.
  assign is_wait = (state == S_W1X) || (state == S_W1F) ||
                   (state == S_W2X) || (state == S_W2F);
  assign op_ovf  = (add_a[15] == add_b[15]) && (add_sum[15] != add_a[15]);
  assign cap_val = (SAT && op_ovf) ? (add_a[15] ? 16'h8000 : 16'h7FFF) : add_sum;

  always_ff @(posedge clck) begin
    if (!rst_n) begin
      x_lat    <= 16'h0000;
      fb_sub   <= 1'b0;
      int1     <= 16'h0000;
      int2     <= 16'h0000;
      dac_bit  <= 1'b0;
      ovf_flag <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            x_lat  <= in_data;
            fb_sub <= dac_bit;
          end
        end
        S_W1X, S_W1F: int1 <= cap_val;
        S_W2X, S_W2F: int2 <= cap_val;
        S_OUT:        dac_bit <= ~int2[15];
        default: ;
      endcase
      if (is_wait && op_ovf) ovf_flag <= 1'b1;
      else if (ovf_clr)      ovf_flag <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sd2_adder_sched.sv
// tb_sd2_adder_sched: randomized checks of two modulator instances (wrap and saturate).
// Revision 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_sd2_adder_sched;

  localparam logic [15:0] M = 16'h4000;

  logic        clck = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        ovf_clr;
  logic [15:0] in_data;
  logic [1:0]  in_ready;
  logic [1:0]  add_cin;
  logic [1:0]  add_cout;
  logic [1:0]  dac_bit;
  logic [1:0]  dout_valid;
  logic [1:0]  ovf_flag;
  logic [15:0] add_a [2];
  logic [15:0] add_b [2];
  logic [15:0] add_sum [2];

  int total = 0;
  int bad   = 0;
  bit garbage = 1'b0;
  int phase = 0;

  logic [15:0] mi1 [2];
  logic [15:0] mi2 [2];
  bit          mdac [2];
  bit          movf [2];

  always #5 clck = ~clck;

  sd2_adder_sched #(.FB_MAG(M), .SAT(1'b0)) u_wrap (
    .clck(clck), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready[0]), .add_a(add_a[0]), .add_b(add_b[0]), .add_cin(add_cin[0]),
    .add_sum(add_sum[0]), .add_cout(add_cout[0]), .dac_bit(dac_bit[0]),
    .dout_valid(dout_valid[0]), .ovf_flag(ovf_flag[0]), .ovf_clr(ovf_clr)
  );

  sd2_adder_sched #(.FB_MAG(M), .SAT(1'b1)) u_sat (
    .clck(clck), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready[1]), .add_a(add_a[1]), .add_b(add_b[1]), .add_cin(add_cin[1]),
    .add_sum(add_sum[1]), .add_cout(add_cout[1]), .dac_bit(dac_bit[1]),
    .dout_valid(dout_valid[1]), .ovf_flag(ovf_flag[1]), .ovf_clr(ovf_clr)
  );

  // Registered adder; in garbage mode only issue cycles (phases 1,3,5,7) yield a real sum.
  always @(posedge clck) begin
    if (!rst_n) phase <= 0;
    else if (in_valid && in_ready[0]) phase <= 1;
    else if (phase != 0) phase <= (phase == 9) ? 0 : phase + 1;
    for (int k = 0; k < 2; k++) begin
      if (garbage && !(phase == 1 || phase == 3 || phase == 5 || phase == 7)) begin
        add_sum[k]  <= 16'($urandom);
        add_cout[k] <= 1'($urandom);
      end else begin
        {add_cout[k], add_sum[k]} <= {1'b0, add_a[k]} + {1'b0, add_b[k]} + {16'h0000, add_cin[k]};
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Signed add with either wrap or clamp; returns {overflow, result}.
  function automatic logic [16:0] sat_add(input bit sat, input int a, input int b);
    int s;
    bit ov;
    logic [15:0] v;
    s  = a + b;
    ov = (s > 32767) || (s < -32768);
    v  = s[15:0];
    if (ov && sat) v = (s > 0) ? 16'h7FFF : 16'h8000;
    return {ov, v};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mi1[k] = 16'h0; mi2[k] = 16'h0; mdac[k] = 1'b0; movf[k] = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; ovf_clr = 1'b0; in_data = 16'h0;
    repeat (3) @(negedge clck);
    rst_n = 1'b1;
    model_reset();
    @(negedge clck);
  endtask

  task automatic run_sample(input logic [15:0] x, input bit hold_valid);
    logic [15:0] ea [2][10];
    logic [15:0] eb [2][10];
    logic        ec [2][10];
    logic [15:0] n1 [2];
    logic [15:0] n2 [2];
    bit          ov [2];
    logic [16:0] r;
    logic [15:0] mid;
    logic [15:0] fop;
    int          fbd;
    int          n;
    n = 0;
    while (in_ready !== 2'b11 && n < 20) begin
      @(negedge clck);
      n++;
    end
    check("ready_wait", {30'd0, in_ready}, 32'd3);
    for (int k = 0; k < 2; k++) begin
      fbd = mdac[k] ? -int'(M) : int'(M);
      fop = mdac[k] ? ~M : M;
      for (int c = 0; c < 10; c++) begin
        ea[k][c] = 16'h0; eb[k][c] = 16'h0; ec[k][c] = 1'b0;
      end
      r = sat_add(k == 1, $signed(mi1[k]), $signed(x));
      ov[k] = r[16]; mid = r[15:0];
      ea[k][1] = mi1[k]; eb[k][1] = x;
      ea[k][3] = mid;    eb[k][3] = fop; ec[k][3] = mdac[k];
      r = sat_add(k == 1, $signed(mid), fbd);
      ov[k] |= r[16]; n1[k] = r[15:0];
      r = sat_add(k == 1, $signed(mi2[k]), $signed(n1[k]));
      ov[k] |= r[16]; mid = r[15:0];
      ea[k][5] = mi2[k]; eb[k][5] = n1[k];
      ea[k][7] = mid;    eb[k][7] = fop; ec[k][7] = mdac[k];
      r = sat_add(k == 1, $signed(mid), fbd);
      ov[k] |= r[16]; n2[k] = r[15:0];
      for (int c = 2; c <= 8; c += 2) begin
        ea[k][c] = ea[k][c-1]; eb[k][c] = eb[k][c-1]; ec[k][c] = ec[k][c-1];
      end
    end
    in_valid = 1'b1;
    in_data  = x;
    @(posedge clck);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clck);
      if (c == 1 && !hold_valid) in_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
        check($sformatf("add_a i%0d c%0d", k, c), {16'd0, add_a[k]}, {16'd0, ea[k][c]});
        check($sformatf("add_b i%0d c%0d", k, c), {16'd0, add_b[k]}, {16'd0, eb[k][c]});
        check($sformatf("ctl i%0d c%0d", k, c),
              {29'd0, add_cin[k], in_ready[k], dout_valid[k]},
              {29'd0, ec[k][c], 1'b0, (c == 9)});
      end
    end
    for (int k = 0; k < 2; k++) begin
      mi1[k] = n1[k]; mi2[k] = n2[k]; mdac[k] = ~n2[k][15]; movf[k] = movf[k] | ov[k];
    end
    @(negedge clck);
    check("ready_after", {30'd0, in_ready}, 32'd3);
    check("dac_bit", {30'd0, dac_bit}, {30'd0, mdac[1], mdac[0]});
    check("ovf_flag", {30'd0, ovf_flag}, {30'd0, movf[1], movf[0]});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [15:0] x;
    int gap;
    do_reset();
    check("rst_ready", {30'd0, in_ready}, 32'd3);
    check("rst_dv", {30'd0, dout_valid}, 32'd0);
    check("rst_dac", {30'd0, dac_bit}, 32'd0);
    check("rst_ovf", {30'd0, ovf_flag}, 32'd0);
    check("rst_ops", {add_a[0], add_b[1]}, 32'd0);

    // First sample from reset: wrap instance overflows int2, saturating one clamps.
    run_sample(16'h1000, 1'b0);
    check("t1_dac", {30'd0, dac_bit}, 32'd2);
    check("t1_ovf", {30'd0, ovf_flag}, 32'd3);
    run_sample(16'h0000, 1'b0);
    ovf_clr = 1'b1;
    @(negedge clck);
    ovf_clr = 1'b0;
    movf[0] = 1'b0; movf[1] = 1'b0;
    check("t2_ovf_clr", {30'd0, ovf_flag}, 32'd0);

    // Zero input stream with in_valid held high.
    do_reset();
    for (int i = 0; i < 40; i++) run_sample(16'h0000, 1'b1);
    in_valid = 1'b0;

    // Reset asserted in the W1F cycle aborts the sample.
    @(negedge clck);
    in_valid = 1'b1;
    in_data  = 16'h2345;
    @(posedge clck);
    in_valid = 1'b0;
    repeat (4) @(negedge clck);
    rst_n = 1'b0;
    @(negedge clck);
    check("t5_ready", {30'd0, in_ready}, 32'd3);
    check("t5_ops", {add_a[0], add_a[1]}, 32'd0);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clck);
      check("t5_no_dv", {30'd0, dout_valid}, 32'd0);
    end
    run_sample(16'h0100, 1'b0);

    // Adder output garbage outside wait states must not matter.
    do_reset();
    garbage = 1'b1;
    for (int i = 0; i < 40; i++) run_sample(16'h0000, 1'b1);
    in_valid = 1'b0;

    for (int i = 0; i < 80; i++) begin
      garbage = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0:       x = 16'h7FFF;
        1:       x = 16'h8000;
        default: x = 16'($urandom);
      endcase
      run_sample(x, 1'($urandom_range(0, 1)));
      gap = $urandom_range(0, 3);
      if (gap > 0) in_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
        if (g == 0 && $urandom_range(0, 2) == 0) begin
          ovf_clr = 1'b1;
          @(negedge clck);
          ovf_clr = 1'b0;
          movf[0] = 1'b0; movf[1] = 1'b0;
          check("rand_ovf_clr", {30'd0, ovf_flag}, 32'd0);
        end else begin
          @(negedge clck);
        end
      end
    end
    in_valid = 1'b0;
    repeat (3) @(negedge clck);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
